// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and opcode helpers.
// Imported by the execute-stage ALU and by the ALU control decoder.
package alu_pkg;

  localparam int unsigned ALU_OP_WIDTH = 4;

  // ALU operation codes produced by the ALU control decoder
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'b0111;

  // Execute-stage sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // True for operations handled by the serial shifter
  function automatic logic op_is_shift(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle logical shifter with a down-counter of remaining steps.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load           capture load_data / load_count / shift_left
//   shift_left     direction for the loaded operation (1 = SLL, 0 = SRL)
//   step           perform one shift step and decrement the count
//   load_data      value to shift
//   load_count     number of steps to perform
//   next_data_c    value after the next step (combinational)
//   last_c         the next step is the final one (combinational)
module alu_serial_shifter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   shift_left,
  input  logic                   step,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic [SHAMT_WIDTH-1:0] load_count,
  output logic [DATA_WIDTH-1:0]  next_data_c,
  output logic                   last_c
);

  logic [DATA_WIDTH-1:0]  data_q;
  logic [SHAMT_WIDTH-1:0] count_q;
  logic                   left_q;

  // One logical step, zero fill
  always_comb begin
    next_data_c = data_q;
    if (left_q) begin
      next_data_c = {data_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      next_data_c = {1'b0, data_q[DATA_WIDTH-1:1]};
    end
  end

  assign last_c = (count_q == SHAMT_WIDTH'(1));

  // Shift register, direction and remaining-step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      count_q <= load_count;
      left_q  <= shift_left;
    end else if (step && (count_q != '0)) begin
      data_q  <= next_data_c;
      count_q <= count_q - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/LUI, serial SRL/SLL,
// with a start/busy/done handshake towards the sequencer.
// Ports:
//   clk              clock, rising edge
//   reset            async active-low reset
//   start_i          request, accepted in IDLE or DONE
//   ALU_Operation_i  operation code (alu_pkg ALU_*)
//   A_i, B_i         operands; shift amount is B_i[SHAMT_WIDTH-1:0]
//   busy_o           shift in progress
//   done_o           one-cycle pulse, result valid from this cycle on
//   ALU_Result_o     result register, held until the next completion
//   Zero_o           result register equals zero
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [ALU_OP_WIDTH-1:0] ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0]   A_i,
  input  logic [DATA_WIDTH-1:0]   B_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   ALU_Result_o,
  output logic                    Zero_o
);

  alu_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   result_d;
  logic                    zero_d;
  logic                    busy_d;
  logic                    done_d;

  logic [SHAMT_WIDTH-1:0]  shamt_c;
  logic [DATA_WIDTH-1:0]   alu_c;
  logic                    shift_load_c;
  logic                    shift_step_c;
  logic [DATA_WIDTH-1:0]   shift_next_c;
  logic                    shift_last_c;

  assign shamt_c = B_i[SHAMT_WIDTH-1:0];

  // Single-cycle datapath; a zero-distance shift passes A through
  always_comb begin
    alu_c = '0;
    case (ALU_Operation_i)
      ALU_ADD: alu_c = A_i + B_i;
      ALU_SUB: alu_c = A_i - B_i;
      ALU_AND: alu_c = A_i & B_i;
      ALU_OR:  alu_c = A_i | B_i;
      ALU_LUI: alu_c = B_i;
      ALU_SRL: alu_c = A_i;
      ALU_SLL: alu_c = A_i;
      default: alu_c = '0;
    endcase
  end

  alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (reset),
    .load        (shift_load_c),
    .shift_left  (ALU_Operation_i == ALU_SLL),
    .step        (shift_step_c),
    .load_data   (A_i),
    .load_count  (shamt_c),
    .next_data_c (shift_next_c),
    .last_c      (shift_last_c)
  );

  // Next state, next result and shifter control
  always_comb begin
    state_d      = state_q;
    result_d     = ALU_Result_o;
    shift_load_c = 1'b0;
    shift_step_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          if (op_is_shift(ALU_Operation_i) && (shamt_c != '0)) begin
            shift_load_c = 1'b1;
            state_d      = SHIFT;
          end else begin
            result_d = alu_c;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        shift_step_c = 1'b1;
        if (shift_last_c) begin
          result_d = shift_next_c;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // result only changes at completion, so Zero tracks it exactly
    zero_d = (result_d == '0);
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ALU_Result_o <= result_d;
      Zero_o       <= zero_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations queued at issue, checked on done_o.
module tb_alu_multicycle;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    string       tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned busy_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned stable_err = 0;
  logic [31:0] hold_ref = '0;
  exp_t        mon_e;

  alu_multicycle dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0101: return b;
      4'b0110: return a >> b[4:0];
      4'b0111: return a << b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // Drive one accepted request and queue its expected result and done cycle
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res);
    exp_t e;
    int unsigned n;
    n = 32'(b[4:0]);
    start_i = 1'b1;
    ALU_Operation_i = op;
    A_i = a;
    B_i = b;
    e.res = exp_res;
    e.tag = tag;
    e.cyc = cyc + ((((op == 4'b0110) || (op == 4'b0111)) && (n != 0)) ? 1 + n : 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while ((sb_q.size() != 0) && (n < 200)) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compare on every done pulse, track busy cycles and hold stability
  always @(negedge clk) begin
    if (reset) begin
      if (busy_o) begin
        busy_cnt++;
        if (ALU_Result_o !== hold_ref) stable_err++;
      end
      if (done_o) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk({mon_e.tag, "_res"}, ALU_Result_o, mon_e.res);
          chk({mon_e.tag, "_zero"}, 32'(Zero_o), 32'(mon_e.res == 32'h0));
          chk({mon_e.tag, "_done_cyc"}, cyc, mon_e.cyc);
          chk({mon_e.tag, "_busy_with_done"}, 32'(busy_o), 32'd0);
          hold_ref = mon_e.res;
        end
      end
    end
  end

  initial begin
    int unsigned b0;
    int unsigned d0;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b0;
    start_i = 1'b0;
    ALU_Operation_i = 4'b0000;
    A_i = '0;
    B_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", ALU_Result_o, 32'h0);
    chk("rst_zero", 32'(Zero_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ADD, single cycle, never busy
    b0 = busy_cnt;
    issue("add", 4'b0000, 32'd5, 32'd7, 32'd12);
    start_i = 1'b0;
    wait_drain("add");
    chk("add_busy_cycles", busy_cnt - b0, 32'd0);

    // SUB to zero and SUB wrap-around
    issue("sub_eq", 4'b0001, 32'd3, 32'd3, 32'h0);
    start_i = 1'b0;
    wait_drain("sub_eq");
    issue("sub_wrap", 4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    start_i = 1'b0;
    wait_drain("sub_wrap");

    // Longest shift and zero-distance shift
    b0 = busy_cnt;
    issue("sll31", 4'b0111, 32'd1, 32'd31, 32'h8000_0000);
    start_i = 1'b0;
    wait_drain("sll31");
    chk("sll31_busy_cycles", busy_cnt - b0, 32'd31);
    issue("sll0", 4'b0111, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
    start_i = 1'b0;
    wait_drain("sll0");

    // SRL with start re-asserted mid-shift: must be ignored
    b0 = busy_cnt;
    d0 = done_cnt;
    issue("srl4", 4'b0110, 32'hF000_0000, 32'd4, 32'h0F00_0000);
    ALU_Operation_i = 4'b0000;
    A_i = 32'd1;
    B_i = 32'd1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    wait_drain("srl4");
    chk("srl4_busy_cycles", busy_cnt - b0, 32'd4);
    chk("srl4_done_pulses", done_cnt - d0, 32'd1);

    // Reset in the middle of a shift
    d0 = done_cnt;
    issue("sll20", 4'b0111, 32'd1, 32'd20, 32'h0010_0000);
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    sb_q.delete();
    hold_ref = '0;
    #1;
    chk("midrst_result", ALU_Result_o, 32'h0);
    chk("midrst_zero", 32'(Zero_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    issue("add_after_rst", 4'b0000, 32'd1, 32'd1, 32'd2);
    start_i = 1'b0;
    wait_drain("add_after_rst");

    // Back-to-back acceptance from DONE, then an unsupported code
    issue("or_b2b", 4'b0011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    issue("bad_b2b", 4'b1000, 32'd5, 32'd6, 32'h0);
    start_i = 1'b0;
    wait_drain("b2b");

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) op = (i % 2 == 0) ? 4'b0110 : 4'b0111;
      issue("rand", op, a, b, ref_alu(op, a, b));
      start_i = 1'b0;
      wait_drain("rand");
    end

    chk("result_stable_while_busy", stable_err, 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
